// File: rtl/muldiv_ctrl_pkg.sv
// Shared pipes package: MDU op encoding, controller states
// and small operand-shaping helpers.
package muldiv_ctrl_pkg;

  typedef enum logic [3:0] {
    MDU_MUL,
    MDU_MULW,
    MDU_DIV,
    MDU_DIVU,
    MDU_REM,
    MDU_REMU,
    MDU_DIVW,
    MDU_DIVUW,
    MDU_REMW,
    MDU_REMUW
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } mdu_state_t;

  function automatic logic is_mul(input mdu_op_t op);
    return op inside {MDU_MUL, MDU_MULW};
  endfunction

  function automatic logic is_w(input mdu_op_t op);
    return op inside {MDU_MULW, MDU_DIVW, MDU_DIVUW,
                      MDU_REMW, MDU_REMUW};
  endfunction

  function automatic logic is_sgn(input mdu_op_t op);
    return op inside {MDU_DIV, MDU_REM, MDU_DIVW, MDU_REMW};
  endfunction

  function automatic logic is_rem(input mdu_op_t op);
    return op inside {MDU_REM, MDU_REMU, MDU_REMW, MDU_REMUW};
  endfunction

  function automatic logic [63:0] sext32(input logic [31:0] v);
    return {{32{v[31]}}, v};
  endfunction

  function automatic logic [63:0] ext(input mdu_op_t op,
                                      input logic [63:0] v);
    if (!is_w(op)) return v;
    if (is_sgn(op)) return sext32(v[31:0]);
    return {32'b0, v[31:0]};
  endfunction

  function automatic logic [63:0] wfix(input mdu_op_t op,
                                       input logic [63:0] v);
    return is_w(op) ? sext32(v[31:0]) : v;
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Execute-stage <-> MDU request/result bundle.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic        valid_i;
  mdu_op_t     op_i;
  logic [63:0] a_i;
  logic [63:0] b_i;
  logic        flush_i;
  logic        ready_o;
  logic        busy_o;
  logic        done_o;
  logic [63:0] c_o;

  modport master (
    output valid_i, op_i, a_i, b_i, flush_i,
    input  ready_o, busy_o, done_o, c_o
  );

  modport slave (
    input  valid_i, op_i, a_i, b_i, flush_i,
    output ready_o, busy_o, done_o, c_o
  );

endinterface

// File: rtl/muldiv_ctrl_iter.sv
// One shift-add (mul) or restoring-subtract (div) step.
module muldiv_iter (
  input  logic        mul_i,
  input  logic [63:0] x_i,
  input  logic [63:0] y_i,
  input  logic [63:0] z_i,
  output logic [63:0] x_o,
  output logic [63:0] y_o,
  output logic [63:0] z_o
);

  logic [64:0] sh;
  logic [64:0] df;

  // mul: x=product y=multiplicand z=multiplier
  // div: x=remainder y=divisor z=dividend/quotient
  always_comb begin
    sh  = {x_i, z_i[63]};
    df  = sh - {1'b0, y_i};
    x_o = x_i;
    y_o = y_i;
    z_o = z_i;
    if (mul_i) begin
      x_o = x_i + (z_i[0] ? y_i : 64'd0);
      y_o = {y_i[62:0], 1'b0};
      z_o = {1'b0, z_i[63:1]};
    end else if (!df[64]) begin
      x_o = df[63:0];
      z_o = {z_i[62:0], 1'b1};
    end else begin
      x_o = sh[63:0];
      z_o = {z_i[62:0], 1'b0};
    end
  end

endmodule

// File: rtl/muldiv_ctrl.sv
// Iterative 64-bit MUL/DIV sequencer: 64 steps per op,
// div-by-zero and signed overflow resolved in one cycle.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         reset,
  muldiv_ctrl_if.slave bus
);

  mdu_state_t  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  mdu_op_t     op_q, op_d;
  logic        qneg_q, qneg_d;
  logic        rneg_q, rneg_d;
  logic [63:0] x_q, x_d, y_q, y_d, z_q, z_d;
  logic [63:0] c_q, c_d;
  logic [63:0] x_n, y_n, z_n;
  logic [63:0] aw, bw, minv, sraw, spec;
  logic [63:0] fraw, fin;
  logic        sgn, na, nb, dz, ovf, acc;

  muldiv_iter u_iter (
    .mul_i (is_mul(op_q)),
    .x_i   (x_q),
    .y_i   (y_q),
    .z_i   (z_q),
    .x_o   (x_n),
    .y_o   (y_n),
    .z_o   (z_n)
  );

  always_comb begin
    aw   = ext(bus.op_i, bus.a_i);
    bw   = ext(bus.op_i, bus.b_i);
    sgn  = is_sgn(bus.op_i);
    na   = sgn & aw[63];
    nb   = sgn & bw[63];
    minv = is_w(bus.op_i) ? 64'hFFFF_FFFF_8000_0000
                          : 64'h8000_0000_0000_0000;
    dz   = !is_mul(bus.op_i) && (bw == 64'd0);
    ovf  = sgn && (aw == minv) && (bw == '1);
    if (dz) sraw = is_rem(bus.op_i) ? aw : '1;
    else    sraw = is_rem(bus.op_i) ? 64'd0 : aw;
    spec = wfix(bus.op_i, sraw);
    acc  = (state_q == S_IDLE) && bus.valid_i && !bus.flush_i;
  end

  always_comb begin
    if (is_mul(op_q))      fraw = x_n;
    else if (is_rem(op_q)) fraw = rneg_q ? -x_n : x_n;
    else                   fraw = qneg_q ? -z_n : z_n;
    fin = wfix(op_q, fraw);
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    x_d     = x_q;
    y_d     = y_q;
    z_d     = z_q;
    c_d     = c_q;
    unique case (state_q)
      S_IDLE: if (acc) begin
        op_d   = bus.op_i;
        cnt_d  = 6'd0;
        qneg_d = na ^ nb;
        rneg_d = na;
        x_d    = 64'd0;
        if (dz || ovf) begin
          state_d = S_DONE;
          c_d     = spec;
        end else begin
          state_d = S_BUSY;
          if (is_mul(bus.op_i)) begin
            y_d = aw;
            z_d = bw;
          end else begin
            y_d = nb ? -bw : bw;
            z_d = na ? -aw : aw;
          end
        end
      end
      S_BUSY: begin
        x_d   = x_n;
        y_d   = y_n;
        z_d   = z_n;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd63) begin
          state_d = S_DONE;
          c_d     = fin;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.flush_i) begin
      state_d = S_IDLE;
      c_d     = c_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      op_q    <= MDU_MUL;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      x_q     <= 64'd0;
      y_q     <= 64'd0;
      z_q     <= 64'd0;
      c_q     <= 64'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      x_q     <= x_d;
      y_q     <= y_d;
      z_q     <= z_d;
      c_q     <= c_d;
    end
  end

  assign bus.ready_o = (state_q == S_IDLE);
  assign bus.busy_o  = (state_q == S_BUSY) || acc;
  assign bus.done_o  = (state_q == S_DONE);
  assign bus.c_o     = c_q;

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Directed bench for muldiv_ctrl: results, latency,
// special cases, flush and reset aborts.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic run_op(input string tag, input mdu_op_t op,
                        input logic [63:0] a,
                        input logic [63:0] b,
                        input logic [63:0] exp,
                        input int lat);
    int n;
    bit seen;
    bit bz;
    @(negedge clk);
    bus.op_i    = op;
    bus.a_i     = a;
    bus.b_i     = b;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    bus.a_i     = ~a;
    bus.b_i     = ~b;
    n    = 0;
    seen = 1'b0;
    bz   = 1'b1;
    while (n < 200 && !seen) begin
      @(negedge clk);
      n++;
      if (bus.done_o) seen = 1'b1;
      else if (!bus.busy_o) bz = 1'b0;
    end
    chk({tag, "_lat"}, 64'(n), 64'(lat));
    chk({tag, "_c"}, bus.c_o, exp);
    if (lat > 1) chk({tag, "_busy"}, 64'(bz), 64'd1);
    @(negedge clk);
    chk({tag, "_pulse"},
        {62'd0, bus.done_o, bus.ready_o}, 64'd1);
  endtask

  task automatic abort_op(input string tag, input bit use_rst,
                          input logic [63:0] exp_c);
    bit dn;
    @(negedge clk);
    bus.op_i    = MDU_DIVU;
    bus.a_i     = 64'd1000;
    bus.b_i     = 64'd7;
    bus.valid_i = 1'b1;
    @(posedge clk);
    #1;
    bus.valid_i = 1'b0;
    repeat (30) @(negedge clk);
    if (use_rst) reset = 1'b1;
    else bus.flush_i = 1'b1;
    @(negedge clk);
    reset       = 1'b0;
    bus.flush_i = 1'b0;
    chk({tag, "_rdy"}, 64'(bus.ready_o), 64'd1);
    chk({tag, "_c"}, bus.c_o, exp_c);
    dn = bus.done_o;
    repeat (3) begin
      @(negedge clk);
      dn = dn | bus.done_o;
    end
    chk({tag, "_nodone"}, 64'(dn), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    bus.op_i    = MDU_MUL;
    bus.a_i     = 64'd0;
    bus.b_i     = 64'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    chk("rst_state",
        {bus.c_o[59:0], bus.ready_o, bus.busy_o,
         bus.done_o, 1'b0}, 64'h8);
    chk("rst_c", bus.c_o, 64'd0);

    run_op("mul", MDU_MUL, 64'd7,
           64'hFFFF_FFFF_FFFF_FFFD,
           64'hFFFF_FFFF_FFFF_FFEB, 65);
    run_op("div", MDU_DIV, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFD, 65);
    run_op("rem", MDU_REM, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divu0", MDU_DIVU, 64'd100, 64'd0,
           64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remu0", MDU_REMU, 64'd100, 64'd0, 64'd100, 1);
    run_op("divw_ovf", MDU_DIVW, 64'h8000_0000,
           64'hFFFF_FFFF, 64'hFFFF_FFFF_8000_0000, 1);
    run_op("remw_ovf", MDU_REMW, 64'h8000_0000,
           64'hFFFF_FFFF, 64'd0, 1);
    run_op("mulw", MDU_MULW, 64'h1_0000_0002,
           64'h4000_0000, 64'hFFFF_FFFF_8000_0000, 65);
    run_op("div_ovf", MDU_DIV, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF,
           64'h8000_0000_0000_0000, 1);
    run_op("rem_ovf", MDU_REM, 64'h8000_0000_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1);
    run_op("mul_max", MDU_MUL, 64'hFFFF_FFFF_FFFF_FFFF,
           64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 65);
    run_op("divu_big", MDU_DIVU, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd16, 64'h0FFF_FFFF_FFFF_FFFF, 65);
    run_op("remu_big", MDU_REMU, 64'hFFFF_FFFF_FFFF_FFFF,
           64'd16, 64'hF, 65);
    run_op("divuw", MDU_DIVUW, 64'hFFFF_FFFF_FFFF_FFFE,
           64'd2, 64'h7FFF_FFFF, 65);
    run_op("remw", MDU_REMW, 64'hFFFF_FFF9, 64'd2,
           64'hFFFF_FFFF_FFFF_FFFF, 65);
    run_op("divw0", MDU_DIVW, 64'd5, 64'h1_0000_0000,
           64'hFFFF_FFFF_FFFF_FFFF, 1);
    run_op("remw0", MDU_REMW, 64'd5, 64'h1_0000_0000,
           64'd5, 1);

    @(negedge clk);
    bus.op_i    = MDU_DIVU;
    bus.a_i     = 64'd9;
    bus.b_i     = 64'd0;
    bus.valid_i = 1'b1;
    bus.flush_i = 1'b1;
    #1;
    chk("rej_busy", 64'(bus.busy_o), 64'd0);
    @(negedge clk);
    bus.valid_i = 1'b0;
    bus.flush_i = 1'b0;
    chk("rej_idle",
        {61'd0, bus.ready_o, bus.done_o, 1'b0}, 64'd4);
    chk("rej_c", bus.c_o, 64'd5);

    abort_op("flush", 1'b0, 64'd5);
    run_op("divu_after", MDU_DIVU, 64'd1000, 64'd7,
           64'd142, 65);
    run_op("remu_after", MDU_REMU, 64'd1000, 64'd7,
           64'd6, 65);
    abort_op("reset", 1'b1, 64'd0);
    run_op("mul_after", MDU_MUL, 64'd6, 64'd7, 64'd42, 65);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 The block SHALL have no parameters; the operand width is fixed at 64 bits (u64).
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 valid_i  input  1  request from execute stage; operands and op stable while high.
REQ-005 op_i  input  mdu_op_t  operation: MUL, MULW, DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
REQ-006 a_i  input  64  rs1 operand.
REQ-007 b_i  input  64  rs2 operand.
REQ-008 flush_i  input  1  pipeline flush; aborts any operation.
REQ-009 ready_o  output  1  high only in IDLE; request accepted on valid_i && ready_o && !flush_i.
REQ-010 busy_o  output  1  stall request to pipeline; high in BUSY, and in IDLE when valid_i && !flush_i.
REQ-011 done_o  output  1  one-cycle pulse; c_o valid.
REQ-012 c_o  output  64  result; holds last value until next done_o.

Function
REQ-013 The FSM SHALL have states IDLE, BUSY, DONE; reset and flush_i force IDLE.
REQ-014 IDLE->BUSY on acceptance of a normal request; IDLE->DONE on acceptance of a special-case request (REQ-019/020).
REQ-015 BUSY SHALL run exactly 64 iterations counted by a 6-bit counter cleared on acceptance; BUSY->DONE when counter wraps 63->0.
REQ-016 DONE SHALL assert done_o for one cycle, then go to IDLE unconditionally; a new request is accepted no earlier than the cycle after DONE.
REQ-017 Latency: accept at edge N -> done_o high during cycle after edge N+65 for normal ops; after edge N+1 for special cases.
REQ-018 MUL: shift-add, low 64 bits of a*b; MULW: low 32 bits of a[31:0]*b[31:0], sign-extended to 64.
REQ-019 Divide by zero (b, or b[31:0] for W ops, zero): quotient = all ones (sign-extended for W), remainder = dividend (sign-extended for W); no iteration.
REQ-020 Signed overflow (DIV/REM: a=0x8000_0000_0000_0000, b=-1; DIVW/REMW: a[31:0]=0x8000_0000, b[31:0]=-1): quotient = dividend, remainder = 0; no iteration.
REQ-021 Division SHALL be restoring on operand magnitudes; signed ops negate results: quotient negative iff signs differ, remainder takes dividend sign (truncating toward zero).
REQ-022 W ops SHALL sign-extend (DIVW/REMW) or zero-extend (DIVUW/REMUW) 32-bit operands to 64 bits before iterating; result bit 31 sign-extended into c_o[63:32].
REQ-023 Operands SHALL be latched on acceptance; a_i/b_i/op_i changes during BUSY have no effect.
REQ-024 flush_i in any state SHALL return to IDLE next edge with no done_o; flush_i with valid_i in IDLE rejects the request; flush_i during DONE suppresses done_o... DONE already asserted in that cycle is honoured, c_o still updated.
REQ-025 c_o SHALL update only on the edge entering DONE.

Reset
REQ-026 On reset: state IDLE, counter 0, c_o = 0, done_o = 0, internal accumulators 0; ready_o = 1 in the following cycle.
REQ-027 Reset mid-operation SHALL discard the operation with no done_o; reset dominates flush_i and valid_i.

Structure
REQ-028 mdu_op_t and the state enum SHALL live in the shared pipes package; alufunc_t is unchanged.
REQ-029 The datapath SHALL be one sub-module, muldiv_iter, performing a single shift-add or restore-subtract step per cycle, sequenced by muldiv_ctrl.

Verification
REQ-030 MUL a=7, b=-3 (0xFFFF_FFFF_FFFF_FFFD) -> done_o 65 cycles after accept, c_o=0xFFFF_FFFF_FFFF_FFEB; busy_o high throughout.
REQ-031 DIV a=-7, b=2 -> c_o=0xFFFF_FFFF_FFFF_FFFD; REM same operands -> c_o=0xFFFF_FFFF_FFFF_FFFF.
REQ-032 DIVU a=100, b=0 -> done_o 1 cycle after accept, c_o=0xFFFF_FFFF_FFFF_FFFF; REMU -> c_o=100.
REQ-033 DIVW a=0x8000_0000, b=0xFFFF_FFFF -> c_o=0xFFFF_FFFF_8000_0000 after 1 cycle; REMW -> c_o=0.
REQ-034 MULW a=0x1_0000_0002, b=0x4000_0000 -> c_o=0xFFFF_FFFF_8000_0000.
REQ-035 Accept DIVU, assert flush_i at iteration 30 -> IDLE next edge, no done_o, c_o unchanged; new request accepted next cycle completes correctly; repeat with reset instead -> c_o=0.
